// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubble, memory-wait freeze, taken-branch flush.
// Define HAZARD_STALL_CNT_EN to enable the Stall_Cnt / Flush_Cnt performance counters.
module hazard_ctrl #(
  parameter int unsigned FLUSH_EXTRA = 0,
  parameter int unsigned MAX_WAIT    = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead_Ex,
  input  logic [4:0]  Rt_Ex,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UsesRt_ID,
  input  logic        BranchTaken_Mem,
  input  logic        MemBusy,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Flush,
  output logic        Pipe_Hold,
  output logic        Timeout_Err,
  output logic [15:0] Stall_Cnt,
  output logic [15:0] Flush_Cnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        pend_br_q, pend_br_d;
  logic        timeout_q, timeout_d;
  logic        load_use;
  logic        br_issue;
  logic        hold;

  assign load_use = MemRead_Ex && (Rt_Ex != '0) &&
                    ((Rt_Ex == Rs_ID) || (UsesRt_ID && (Rt_Ex == Rt_ID)));

  always_comb begin
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    Pipe_Hold    = 1'b0;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    wcnt_d       = '0;
    pend_br_d    = pend_br_q;
    timeout_d    = timeout_q;
    br_issue     = 1'b0;
    hold         = 1'b0;

    if (!Rst) begin
      unique case (state_q)
        RUN: begin
          if (MemBusy) begin
            hold      = 1'b1;
            pend_br_d = BranchTaken_Mem;
            state_d   = MEMWAIT;
          end else if (BranchTaken_Mem) begin
            br_issue = 1'b1;
          end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
          end
        end
        MEMWAIT: begin
          if (MemBusy) begin
            hold      = 1'b1;
            pend_br_d = pend_br_q | BranchTaken_Mem;
          end else begin
            pend_br_d = 1'b0;
            // A branch still presented on the release cycle is honoured too, not only a latched one.
            if (pend_br_q || BranchTaken_Mem) br_issue = 1'b1;
            else                              state_d  = RUN;
          end
        end
        FLUSH: begin
          IF_ID_Flush = 1'b1;
          if (MemBusy) begin
            hold      = 1'b1;
            pend_br_d = pend_br_q | BranchTaken_Mem;
          end else if (pend_br_q || BranchTaken_Mem) begin
            pend_br_d = 1'b0;
            br_issue  = 1'b1;
          end else begin
            fcnt_d = fcnt_q - 4'd1;
            if (fcnt_q == 4'd1) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      if (hold) begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        Pipe_Hold   = 1'b1;
        wcnt_d      = (wcnt_q == '1) ? wcnt_q : wcnt_q + 16'd1;
        if (wcnt_q >= 16'(MAX_WAIT)) timeout_d = 1'b1;
      end

      if (br_issue) begin
        PCWrite      = 1'b1;
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        EX_MEM_Flush = 1'b1;
        if (FLUSH_EXTRA > 0) begin
          state_d = FLUSH;
          fcnt_d  = 4'(FLUSH_EXTRA);
        end else begin
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= RUN;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      pend_br_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      pend_br_q <= pend_br_d;
      timeout_q <= timeout_d;
    end
  end

  assign Timeout_Err = timeout_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PCWrite && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (br_issue && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;
`else
  assign Stall_Cnt = '0;
  assign Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_EXTRA=2, MAX_WAIT=4.
module tb_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        MemRead_Ex = 1'b0;
  logic [4:0]  Rt_Ex = '0;
  logic [4:0]  Rs_ID = '0;
  logic [4:0]  Rt_ID = '0;
  logic        UsesRt_ID = 1'b0;
  logic        BranchTaken_Mem = 1'b0;
  logic        MemBusy = 1'b0;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Pipe_Hold;
  logic        Timeout_Err;
  logic [15:0] Stall_Cnt, Flush_Cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Pipe_Hold}
  localparam logic [5:0] DEF    = 6'b110000;
  localparam logic [5:0] LU     = 6'b000100;
  localparam logic [5:0] BR     = 6'b111110;
  localparam logic [5:0] FL     = 6'b111000;
  localparam logic [5:0] HOLD   = 6'b000001;
  localparam logic [5:0] FLHOLD = 6'b001001;

  hazard_ctrl #(.FLUSH_EXTRA(2), .MAX_WAIT(4)) dut (
    .Clk(Clk), .Rst(Rst), .MemRead_Ex(MemRead_Ex), .Rt_Ex(Rt_Ex), .Rs_ID(Rs_ID),
    .Rt_ID(Rt_ID), .UsesRt_ID(UsesRt_ID), .BranchTaken_Mem(BranchTaken_Mem),
    .MemBusy(MemBusy), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Flush(EX_MEM_Flush),
    .Pipe_Hold(Pipe_Hold), .Timeout_Err(Timeout_Err), .Stall_Cnt(Stall_Cnt),
    .Flush_Cnt(Flush_Cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the Mealy outputs before the rising edge.
  task automatic step(input string tag, input logic rst, input logic mr, input logic [4:0] rte,
                      input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                      input logic bt, input logic mb, input logic [5:0] expv, input logic eto);
    logic [5:0] obs;
    @(negedge Clk);
    Rst = rst; MemRead_Ex = mr; Rt_Ex = rte; Rs_ID = rs; Rt_ID = rt;
    UsesRt_ID = ur; BranchTaken_Mem = bt; MemBusy = mb;
    #2;
    obs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Pipe_Hold};
    chk({tag, ".ctl"}, 32'(obs), 32'(expv));
    chk({tag, ".tmo"}, 32'(Timeout_Err), 32'(eto));
`ifdef HAZARD_STALL_CNT_EN
    chk({tag, ".cnt"}, {Stall_Cnt, Flush_Cnt}, {exp_stall[15:0], exp_flush[15:0]});
    if (rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!expv[5]) exp_stall++;
      if (expv == BR) exp_flush++;
    end
`else
    chk({tag, ".cnt"}, {Stall_Cnt, Flush_Cnt}, 32'h0);
`endif
  endtask

  initial begin
    step("rst",       1, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    step("idle",      0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);

    step("lu_rs",     0, 1, 5, 5, 0, 0, 0, 0, LU,  0);
    step("lu_after",  0, 0, 5, 2, 0, 0, 0, 0, DEF, 0);
    step("lu_r0",     0, 1, 0, 0, 0, 1, 0, 0, DEF, 0);
    step("lu_nort",   0, 1, 7, 3, 7, 0, 0, 0, DEF, 0);
    step("lu_rt",     0, 1, 7, 3, 7, 1, 0, 0, LU,  0);
    step("lu_nohz",   0, 1, 7, 3, 8, 1, 0, 0, DEF, 0);

    // Taken branch squashes a simultaneous load-use
    step("br0",       0, 1, 5, 5, 0, 0, 1, 0, BR,  0);
    step("br1",       0, 0, 0, 0, 0, 0, 0, 0, FL,  0);
    step("br2",       0, 0, 0, 0, 0, 0, 0, 0, FL,  0);
    step("br3",       0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);

    // Busy takes priority over a load-use; branch arrives mid-wait
    step("mw0",       0, 1, 5, 5, 0, 0, 0, 1, HOLD, 0);
    step("mw1",       0, 0, 0, 0, 0, 0, 0, 1, HOLD, 0);
    step("mw2",       0, 0, 0, 0, 0, 0, 1, 1, HOLD, 0);
    step("mw3",       0, 0, 0, 0, 0, 0, 0, 1, HOLD, 0);
    step("mw_rel",    0, 0, 0, 0, 0, 0, 0, 0, BR,   0);
    step("mw_fl1",    0, 0, 0, 0, 0, 0, 0, 0, FL,   0);
    step("mw_fl2",    0, 0, 0, 0, 0, 0, 0, 0, FL,   0);
    step("mw_run",    0, 0, 0, 0, 0, 0, 0, 0, DEF,  0);

    // Busy during FLUSH freezes the flush countdown
    step("fb_br",     0, 0, 0, 0, 0, 0, 1, 0, BR,     0);
    step("fb_h0",     0, 0, 0, 0, 0, 0, 0, 1, FLHOLD, 0);
    step("fb_h1",     0, 0, 0, 0, 0, 0, 0, 1, FLHOLD, 0);
    step("fb_fl1",    0, 0, 0, 0, 0, 0, 0, 0, FL,     0);
    step("fb_fl2",    0, 0, 0, 0, 0, 0, 0, 0, FL,     0);
    step("fb_run",    0, 0, 0, 0, 0, 0, 0, 0, DEF,    0);

    for (int i = 0; i < 10; i++)
      step($sformatf("to%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, HOLD, (i >= 5) ? 1'b1 : 1'b0);
    step("to_rel",    0, 0, 0, 0, 0, 0, 0, 0, DEF, 1);
    step("to_sticky", 0, 0, 0, 0, 0, 0, 0, 0, DEF, 1);

    step("rf_br",     0, 0, 0, 0, 0, 0, 1, 0, BR,  1);
    step("rf_rst",    1, 0, 0, 0, 0, 0, 0, 0, DEF, 1);
    step("rf_run",    0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    step("rf_lu",     0, 1, 9, 1, 9, 1, 0, 0, LU,  0);
    step("rf_end",    0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
